eth_hdr_tx: RTL and testbench

Serializes one Ethernet frame (parallel header fields plus AXI-Stream payload) into a single 8-bit AXI-Stream byte stream: 6-byte destination MAC, 6-byte source MAC, 2-byte EtherType, then the payload. It sits directly downstream of the Ethernet arbiter/mux and feeds the MAC transmit path. Frames are emitted back-to-back at one byte per cycle when the sink does not stall.

---
 rtl/eth_hdr_tx.sv | 130 +++++++++++++
 tb/tb_eth_hdr_tx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_hdr_tx.sv
// Ethernet header serializer: emits dest MAC, source MAC, EtherType and then the
// payload as one 8-bit AXI-Stream, one byte per cycle, frames back-to-back.
module eth_hdr_tx #(
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [7:0]            s_eth_axi_payload_tdata,
  input  logic                  s_eth_axi_payload_tvalid,
  output logic                  s_eth_axi_payload_tready,
  input  logic                  s_eth_axi_payload_tlast,
  input  logic [USER_WIDTH-1:0] s_eth_axi_payload_tuser,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  busy
);

  // state   | meaning
  // IDLE    | waiting for a header; drains the last byte of the previous frame
  // HEADER  | shifting out the remaining header bytes
  // PAYLOAD | passing payload beats through until tlast
  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_PAYLOAD} state_t;

  state_t                state_q, state_d;
  logic [3:0]            hdr_cnt_q, hdr_cnt_d;
  logic [111:0]          hdr_sr_q, hdr_sr_d;
  logic [7:0]            tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [USER_WIDTH-1:0] tuser_q, tuser_d;
  logic                  out_en;

  assign out_en = m_axis_tready || !tvalid_q;

  always_comb begin
    state_d                  = state_q;
    hdr_cnt_d                = hdr_cnt_q;
    hdr_sr_d                 = hdr_sr_q;
    tdata_d                  = tdata_q;
    tvalid_d                 = tvalid_q;
    tlast_d                  = tlast_q;
    tuser_d                  = tuser_q;
    s_eth_hdr_ready          = 1'b0;
    s_eth_axi_payload_tready = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        s_eth_hdr_ready = 1'b1;
        if (out_en) tvalid_d = 1'b0;
        if (s_eth_hdr_valid) begin
          state_d = ST_HEADER;
          // Byte 0 goes straight to the output so a new frame follows the
          // previous tlast with no bubble; hdr_cnt counts bytes already loaded.
          if (out_en) begin
            tdata_d   = s_eth_dest_mac[47:40];
            tvalid_d  = 1'b1;
            tlast_d   = 1'b0;
            tuser_d   = '0;
            hdr_sr_d  = {s_eth_dest_mac[39:0], s_eth_src_mac, s_eth_type, 8'h00};
            hdr_cnt_d = 4'd1;
          end else begin
            hdr_sr_d  = {s_eth_dest_mac, s_eth_src_mac, s_eth_type};
            hdr_cnt_d = 4'd0;
          end
        end
      end
      ST_HEADER: begin
        if (out_en) begin
          tdata_d   = hdr_sr_q[111:104];
          tvalid_d  = 1'b1;
          tlast_d   = 1'b0;
          tuser_d   = '0;
          hdr_sr_d  = {hdr_sr_q[103:0], 8'h00};
          hdr_cnt_d = hdr_cnt_q + 4'd1;
          if (hdr_cnt_q == 4'd13) state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        s_eth_axi_payload_tready = out_en;
        if (out_en) begin
          if (s_eth_axi_payload_tvalid) begin
            tdata_d  = s_eth_axi_payload_tdata;
            tvalid_d = 1'b1;
            tlast_d  = s_eth_axi_payload_tlast;
            tuser_d  = s_eth_axi_payload_tuser;
            if (s_eth_axi_payload_tlast) state_d = ST_IDLE;
          end else begin
            tvalid_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hdr_cnt_q <= 4'd0;
      hdr_sr_q  <= '0;
      tdata_q   <= 8'h00;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tuser_q   <= '0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      hdr_sr_q  <= hdr_sr_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tuser_q   <= tuser_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_eth_hdr_tx.sv
// Directed bench for eth_hdr_tx: single frame, backpressure, back-to-back,
// tuser passthrough, reset mid-frame and payload gaps.
`timescale 1ns/1ps
module tb_eth_hdr_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_eth_hdr_valid = 1'b0;
  logic        s_eth_hdr_ready;
  logic [47:0] s_eth_dest_mac = '0;
  logic [47:0] s_eth_src_mac = '0;
  logic [15:0] s_eth_type = '0;
  logic [7:0]  pl_tdata = '0;
  logic        pl_tvalid = 1'b0;
  logic        pl_tready;
  logic        pl_tlast = 1'b0;
  logic [0:0]  pl_tuser = '0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic [0:0]  m_axis_tuser;
  logic        busy;

  eth_hdr_tx #(.USER_WIDTH(1)) dut (
    .clk(clk), .reset(reset),
    .s_eth_hdr_valid(s_eth_hdr_valid), .s_eth_hdr_ready(s_eth_hdr_ready),
    .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
    .s_eth_axi_payload_tdata(pl_tdata), .s_eth_axi_payload_tvalid(pl_tvalid),
    .s_eth_axi_payload_tready(pl_tready), .s_eth_axi_payload_tlast(pl_tlast),
    .s_eth_axi_payload_tuser(pl_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int gap; logic [7:0] d; logic last; logic user;} beat_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          bubbles = 0;
  int          pend = 0;
  bit          started = 0;
  int          hs_cyc = 0;
  int          pl_last_cyc = 0;
  bit          pl_took = 0;
  bit          prev_stall = 0;
  logic [10:0] prev_out = '0;
  bit          bp_mode = 0;
  int          bp_idx = 0;
  logic [3:0]  bp_pat = 4'b1001;
  int          gap_left = 0;
  bit          gap_loaded = 0;
  beat_t       pl_q[$];
  logic [9:0]  cap_q[$];
  logic [9:0]  exp_q[$];
  logic [7:0]  t1 [17] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hAA, 8'hBB, 8'hCC,
                           8'hDD, 8'hEE, 8'hFF, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: records accepted bytes, counts interior bubbles, checks stalls.
  always @(negedge clk) begin
    pl_took = pl_tvalid && pl_tready;
    if (pl_took && pl_tlast) pl_last_cyc = cyc;
    if (!reset) begin
      if (prev_stall)
        chk("stall_hold", {21'd0, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata}, {21'd0, prev_out});
      if (m_axis_tvalid && !m_axis_tready) chk("stall_pl_ready", {31'd0, pl_tready}, 32'd0);
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_out   = {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready) begin
        cap_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
        if (started) bubbles += pend;
        started = 1;
        pend = 0;
      end else if (started && !m_axis_tvalid) begin
        pend++;
      end
    end
  end

  // Payload source: each beat may be preceded by a number of idle cycles.
  always @(posedge clk) begin
    #1;
    if (pl_took) begin
      void'(pl_q.pop_front());
      gap_loaded = 0;
    end
    pl_tvalid = 1'b0;
    if (pl_q.size() > 0) begin
      if (!gap_loaded) begin
        gap_left = pl_q[0].gap;
        gap_loaded = 1;
      end
      if (gap_left > 0) begin
        gap_left--;
      end else begin
        pl_tvalid = 1'b1;
        pl_tdata  = pl_q[0].d;
        pl_tlast  = pl_q[0].last;
        pl_tuser  = pl_q[0].user;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      m_axis_tready = bp_pat[bp_idx];
      bp_idx = (bp_idx + 1) % 4;
    end else begin
      m_axis_tready = 1'b1;
    end
  end

  task automatic add_pl(input int gap, input logic [7:0] d, input logic last, input logic user);
    beat_t b;
    b.gap = gap; b.d = d; b.last = last; b.user = user;
    pl_q.push_back(b);
  endtask

  task automatic exp_byte(input logic [7:0] d, input logic last, input logic user);
    exp_q.push_back({user, last, d});
  endtask

  task automatic exp_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
    logic [111:0] h;
    h = {d, s, t};
    for (int i = 0; i < 14; i++) exp_q.push_back({2'b00, h[111-8*i -: 8]});
  endtask

  task automatic clr();
    cap_q.delete();
    exp_q.delete();
    bubbles = 0;
    pend = 0;
    started = 0;
  endtask

  task automatic send_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
    s_eth_hdr_valid = 1'b1;
    s_eth_dest_mac = d;
    s_eth_src_mac = s;
    s_eth_type = t;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_eth_hdr_ready) begin
        hs_cyc = cyc;
        @(posedge clk);
        #1;
        s_eth_hdr_valid = 1'b0;
        return;
      end
    end
    chk("hdr_timeout", 32'd1, 32'd0);
    s_eth_hdr_valid = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input int n);
    int k;
    k = 0;
    while (cap_q.size() < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_count"}, cap_q.size(), n);
    for (int i = 0; i < n && i < cap_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), {22'd0, cap_q[i]}, {22'd0, exp_q[i]});
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    idle_cycles(3);
    reset = 1'b0;
    idle_cycles(1);
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
    chk("rst_tuser", {31'd0, m_axis_tuser}, 32'd0);
    chk("rst_tdata", {24'd0, m_axis_tdata}, 32'd0);
    chk("rst_hdr_ready", {31'd0, s_eth_hdr_ready}, 32'd1);
    chk("rst_pl_tready", {31'd0, pl_tready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // single frame
    clr();
    for (int i = 0; i < 17; i++) exp_byte(t1[i], i == 16, 1'b0);
    add_pl(0, 8'h01, 1'b0, 1'b0);
    add_pl(0, 8'h02, 1'b0, 1'b0);
    add_pl(0, 8'h03, 1'b1, 1'b0);
    send_hdr(48'h001122334455, 48'hAABBCCDDEEFF, 16'h0800);
    chk("t1_first_valid", {31'd0, m_axis_tvalid}, 32'd1);
    chk("t1_first_byte", {24'd0, m_axis_tdata}, 32'h00);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_hdr_ready_low", {31'd0, s_eth_hdr_ready}, 32'd0);
    wait_frame("t1", 17);
    chk("t1_bubbles", bubbles, 32'd0);
    idle_cycles(2);
    chk("t1_busy_done", {31'd0, busy}, 32'd0);
    chk("t1_hdr_ready_done", {31'd0, s_eth_hdr_ready}, 32'd1);

    // backpressure 1,0,0,1
    clr();
    bp_idx = 0;
    bp_mode = 1;
    for (int i = 0; i < 17; i++) exp_byte(t1[i], i == 16, 1'b0);
    add_pl(0, 8'h01, 1'b0, 1'b0);
    add_pl(0, 8'h02, 1'b0, 1'b0);
    add_pl(0, 8'h03, 1'b1, 1'b0);
    send_hdr(48'h001122334455, 48'hAABBCCDDEEFF, 16'h0800);
    wait_frame("t2", 17);
    bp_mode = 0;
    idle_cycles(3);

    // back-to-back, second header presented while busy
    clr();
    exp_hdr(48'h102030405060, 48'h0A0B0C0D0E0F, 16'h86DD);
    exp_byte(8'h5A, 1'b1, 1'b0);
    exp_hdr(48'hF0E0D0C0B0A0, 48'h123456789ABC, 16'h0806);
    exp_byte(8'hC3, 1'b0, 1'b0);
    exp_byte(8'h3C, 1'b1, 1'b0);
    add_pl(0, 8'h5A, 1'b1, 1'b0);
    add_pl(0, 8'hC3, 1'b0, 1'b0);
    add_pl(0, 8'h3C, 1'b1, 1'b0);
    send_hdr(48'h102030405060, 48'h0A0B0C0D0E0F, 16'h86DD);
    send_hdr(48'hF0E0D0C0B0A0, 48'h123456789ABC, 16'h0806);
    chk("t3_hdr2_accept_cycle", hs_cyc, pl_last_cyc + 1);
    wait_frame("t3", 31);
    chk("t3_bubbles", bubbles, 32'd0);
    idle_cycles(3);

    // tuser passthrough
    clr();
    exp_hdr(48'h0002B3C4D5E6, 48'h665544332211, 16'h88B5);
    exp_byte(8'h77, 1'b0, 1'b0);
    exp_byte(8'h88, 1'b1, 1'b1);
    add_pl(0, 8'h77, 1'b0, 1'b0);
    add_pl(0, 8'h88, 1'b1, 1'b1);
    send_hdr(48'h0002B3C4D5E6, 48'h665544332211, 16'h88B5);
    wait_frame("t4", 16);
    idle_cycles(3);

    // reset while header byte 5 is on the output
    clr();
    send_hdr(48'h001122334455, 48'hAABBCCDDEEFF, 16'h0800);
    idle_cycles(5);
    chk("t5_byte5", {24'd0, m_axis_tdata}, 32'h55);
    reset = 1'b1;
    idle_cycles(1);
    reset = 1'b0;
    chk("t5_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_hdr_ready", {31'd0, s_eth_hdr_ready}, 32'd1);
    clr();
    exp_hdr(48'h0C0D0E0F1011, 48'h2122232425A6, 16'h0800);
    exp_byte(8'hE1, 1'b1, 1'b0);
    add_pl(0, 8'hE1, 1'b1, 1'b0);
    send_hdr(48'h0C0D0E0F1011, 48'h2122232425A6, 16'h0800);
    wait_frame("t5", 15);
    idle_cycles(3);

    // reset together with a header handshake
    reset = 1'b1;
    s_eth_hdr_valid = 1'b1;
    idle_cycles(1);
    reset = 1'b0;
    s_eth_hdr_valid = 1'b0;
    idle_cycles(1);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_tvalid", {31'd0, m_axis_tvalid}, 32'd0);

    // payload gap of 3 cycles
    clr();
    exp_hdr(48'h0123456789AB, 48'hCDEF01234567, 16'h0800);
    exp_byte(8'hA1, 1'b0, 1'b0);
    exp_byte(8'hA2, 1'b0, 1'b0);
    exp_byte(8'hA3, 1'b1, 1'b0);
    add_pl(0, 8'hA1, 1'b0, 1'b0);
    add_pl(3, 8'hA2, 1'b0, 1'b0);
    add_pl(0, 8'hA3, 1'b1, 1'b0);
    send_hdr(48'h0123456789AB, 48'hCDEF01234567, 16'h0800);
    wait_frame("t7", 17);
    chk("t7_bubbles", bubbles, 32'd3);
    idle_cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
